// File: rtl/gpr_pkg.sv
// Shared types and default sizes for the multi-port GPR.
package gpr_pkg;

    typedef enum logic {
        GPR_IDLE,
        GPR_CLEAR
    } gpr_state_e;

    localparam int GPR_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;

endpackage

// File: rtl/gpr_rd_port.sv
// One combinational read port: hard-zero entry, then load bypass, then ALU bypass, then storage.
module gpr_rd_port
    import gpr_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic              byp_en,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] entry,
    output logic [DATA_W-1:0] rd
);

    always_comb begin
        rd = entry;
        if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
        end else if (byp_en && we1 && (wa1 == ra)) begin
            rd = wd1;
        end else if (byp_en && we0 && (wa0 == ra)) begin
            rd = wd0;
        end
    end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port GPR with two prioritised write ports, bypassed reads and a sequential bulk-clear engine.
// Optional pending-bit scoreboard enabled by defining GPR_SCOREBOARD_EN.
//   state     | meaning
//   GPR_IDLE  | normal operation, writes commit, clr_req sampled
//   GPR_CLEAR | zero one entry per cycle, writes dropped
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
`ifdef GPR_SCOREBOARD_EN
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_a,
    output logic [NUM_RD-1:0]        pend,
`endif
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    gpr_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              last;
    logic              wr0_ok, wr1_ok;

    assign busy   = (state == GPR_CLEAR);
    assign last   = busy && (cnt == LAST);
    assign wr0_ok = we0 && ((ZERO_REG == 0) || (wa0 != '0));
    assign wr1_ok = we1 && ((ZERO_REG == 0) || (wa1 != '0));

    always_comb begin
        state_nxt = state;
        case (state)
            GPR_IDLE:  if (clr_req) state_nxt = GPR_CLEAR;
            GPR_CLEAR: if (last)    state_nxt = GPR_IDLE;
            default:                state_nxt = GPR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= GPR_IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_done <= last;
            wr_drop  <= busy && (we0 || we1);
            if (!busy) begin
                cnt <= '0;
            end else if (!last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0_ok) mem[wa0] <= wd0;
            if (wr1_ok) mem[wa1] <= wd1;
        end
    end

`ifdef GPR_SCOREBOARD_EN
    logic [DEPTH-1:0] pending;
    logic             alloc_ok;

    assign alloc_ok = alloc_en && ((ZERO_REG == 0) || (alloc_a != '0));

    // Allocation is applied last so it beats a same-cycle retiring write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            if (busy) begin
                pending[cnt] <= 1'b0;
            end else begin
                if (wr0_ok) pending[wa0] <= 1'b0;
                if (wr1_ok) pending[wa1] <= 1'b0;
            end
            if (alloc_ok) pending[alloc_a] <= 1'b1;
        end
    end
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        gpr_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .ra     (ra_k),
            .byp_en (~busy),
            .we0    (we0),
            .wa0    (wa0),
            .wd0    (wd0),
            .we1    (we1),
            .wa1    (wa1),
            .wd1    (wd1),
            .entry  (mem[ra_k]),
            .rd     (rd[k*DATA_W +: DATA_W])
        );

`ifdef GPR_SCOREBOARD_EN
        assign pend[k] = pending[ra_k];
`endif
    end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
Parametrised multi-port general-purpose register file for the datapath. It is the successor to the single-write/two-read GPR.
- Configurable data width, depth and read-port count.
- Two write ports with fixed priority.
- Write-to-read bypass.
- Optional hard-wired zero register.
- Sequential bulk-clear engine usable without asserting reset.
- Sits between decode (read addresses) and writeback (ALU and load-return write ports).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low
we0  in  1  write enable, port 0 (ALU writeback)
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (load writeback, higher priority)
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
ra  in  NUM_RD*ADDR_W  packed read addresses; port k is ra[k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  packed read data, same packing as ra
clr_req  in  1  start bulk clear; level is sampled only in IDLE
busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when clear completes
wr_drop  out  1  registered pulse; a write was discarded because of a clear

Behaviour:
- Reset (rst=0, asynchronous):
  - All entries become 0.
  - FSM goes to IDLE and the clear counter goes to 0.
  - busy=0, clr_done=0, wr_drop=0.
  - Takes effect without a clock edge.
  - Reset mid-clear aborts the clear; clr_done does not pulse.
- Reads:
  - Combinational, zero latency.
  - Priority for rd[k], highest first:
    1. ZERO_REG=1 and ra[k]==0 → 0.
    2. we1 && wa1==ra[k] → wd1.
    3. we0 && wa0==ra[k] → wd0.
    4. Otherwise the stored entry.
  - Bypass is suppressed when busy=1 (pending writes are dropped in that case).
- Writes:
  - Occur at the rising edge.
  - If both ports write the same address, port 1 wins and port 0 is lost silently; wr_drop is not raised.
  - ZERO_REG=1: writes to address 0 are ignored.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when clr_req=1. Counter=0, busy=1 from the next cycle.
  - In CLEAR, one entry per cycle: entry[counter] <= 0, then counter++.
  - When counter==DEPTH-1 is written, the FSM returns to IDLE next cycle. clr_done=1 for exactly that cycle and busy=0.
  - Total busy duration is DEPTH cycles.
  - In CLEAR, all writes (we0/we1) are discarded. wr_drop=1 on the following cycle if any we was high.
  - clr_req while in CLEAR is ignored; no restart.
  - Counter wraps are not possible: it is ADDR_W bits and stops at DEPTH-1.
  - A write in the same cycle that clr_req is sampled in IDLE is performed; the clear begins next cycle and overwrites it.
- Reads during CLEAR return the current array contents, which is a mix of cleared and uncleared entries.

Optional Feature:
GPR_SCOREBOARD_EN
- Defined, the block adds:
  - Ports alloc_en (in, 1), alloc_a (in, ADDR_W) and pend (out, NUM_RD).
  - A DEPTH-bit pending vector, reset to 0. alloc_en sets bit alloc_a at the edge.
  - Any committed write to address a clears bit a. When alloc and write target the same address in the same cycle, alloc (set) wins.
  - pend[k] = pending[ra[k]], combinational, not bypassed.
  - Bulk clear zeroes the pending bits with their entries.
  - ZERO_REG=1: bit 0 is never set.
- Undefined: none of these ports or state exist.

Decomposition:
- Package gpr_pkg holds the FSM state enum (GPR_IDLE, GPR_CLEAR) and localparam defaults GPR_DATA_W=32 and GPR_ADDR_W=5.
- One sub-module, gpr_rd_port: a single bypassed read mux, instantiated NUM_RD times in a generate loop.
- The clear FSM and storage stay in the top.

Test Plan:
- Reset, then write we0 wa0=3 wd0=0xDEADBEEF; next cycle ra[0]=3 → rd[0]=0xDEADBEEF. Assert rst=0 mid-cycle → rd[0]=0 immediately.
- Same cycle: we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22, ra[1]=7 → rd[1]=0x22 combinationally and after the edge. Then ra=0 with we1 wa1=0 wd1=0x55 (ZERO_REG=1) → rd=0, stays 0.
- Fill all 32 entries with index+1, pulse clr_req:
  - busy=1 for exactly 32 cycles.
  - clr_done pulses once on cycle 33.
  - All entries read 0.
  - A we0 wa0=4 issued during busy → wr_drop=1 next cycle, entry 4 still 0.
- Start clear, assert rst=0 at cycle 10 → busy=0, no clr_done, all entries 0. A subsequent clr_req restarts from entry 0.
- GPR_SCOREBOARD_EN:
  - alloc_en alloc_a=9, then ra[0]=9 → pend[0]=1.
  - we0 wa0=9 → pend[0]=0 next cycle.
  - Simultaneous alloc and write to 9 → pend stays 1.
